// File: rtl/dmux2.sv
// Registered 1-to-2 demultiplexer with per-channel valid flags and
// saturating route counters; the unselected output idles at IDLE_VAL.
module dmux2 #(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s0,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic             z0_vld,
  output logic             z1_vld,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_ONE;
    end
  endfunction

  logic [WIDTH-1:0] z0_r, z1_r, z0_s, z1_s;
  logic             z0_vld_r, z1_vld_r, z0_vld_s, z1_vld_s;
  logic [CNT_W-1:0] cnt0_r, cnt1_r, cnt0_s, cnt1_s;

  // Next-state routing: hold everything unless enabled with a known select.
  always_comb begin
    z0_s     = z0_r;
    z1_s     = z1_r;
    z0_vld_s = z0_vld_r;
    z1_vld_s = z1_vld_r;
    cnt0_s   = cnt0_r;
    cnt1_s   = cnt1_r;
    if (en) begin
      case (s0)
        1'b0: begin
          z0_s     = d0;
          z1_s     = IDLE_VAL;
          z0_vld_s = 1'b1;
          z1_vld_s = 1'b0;
          cnt0_s   = sat_inc(cnt0_r);
        end
        1'b1: begin
          z0_s     = IDLE_VAL;
          z1_s     = d0;
          z0_vld_s = 1'b0;
          z1_vld_s = 1'b1;
          cnt1_s   = sat_inc(cnt1_r);
        end
        default: begin
          z0_s     = z0_r;
          z1_s     = z1_r;
          z0_vld_s = z0_vld_r;
          z1_vld_s = z1_vld_r;
          cnt0_s   = cnt0_r;
          cnt1_s   = cnt1_r;
        end
      endcase
    end else begin
      z0_s = z0_r;
      z1_s = z1_r;
    end
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      z0_r     <= IDLE_VAL;
      z1_r     <= IDLE_VAL;
      z0_vld_r <= 1'b0;
      z1_vld_r <= 1'b0;
      cnt0_r   <= CNT_ZERO;
      cnt1_r   <= CNT_ZERO;
    end else begin
      z0_r     <= z0_s;
      z1_r     <= z1_s;
      z0_vld_r <= z0_vld_s;
      z1_vld_r <= z1_vld_s;
      cnt0_r   <= cnt0_s;
      cnt1_r   <= cnt1_s;
    end
  end

  assign z0     = z0_r;
  assign z1     = z1_r;
  assign z0_vld = z0_vld_r;
  assign z1_vld = z1_vld_r;
  assign cnt0   = cnt0_r;
  assign cnt1   = cnt1_r;

endmodule

// File: tb/tb_dmux2.sv
// Directed bench for dmux2 using three configurations: default, narrow
// counters (CNT_W=2) and byte-wide data with an all-ones idle value.
module tb_dmux2;

  logic clk;
  int   n_vec;
  int   n_err;

  // Instance A: defaults (WIDTH=1, IDLE_VAL=0, CNT_W=8)
  logic       rst_a, en_a, s0_a;
  logic [0:0] d0_a, z0_a, z1_a;
  logic       z0v_a, z1v_a;
  logic [7:0] cnt0_a, cnt1_a;

  // Instance B: CNT_W=2
  logic       rst_b, en_b, s0_b;
  logic [0:0] d0_b, z0_b, z1_b;
  logic       z0v_b, z1v_b;
  logic [1:0] cnt0_b, cnt1_b;

  // Instance C: WIDTH=8, IDLE_VAL=8'hFF
  logic       rst_c, en_c, s0_c;
  logic [7:0] d0_c, z0_c, z1_c;
  logic       z0v_c, z1v_c;
  logic [7:0] cnt0_c, cnt1_c;

  dmux2 u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .s0(s0_a), .d0(d0_a),
    .z0(z0_a), .z1(z1_a), .z0_vld(z0v_a), .z1_vld(z1v_a),
    .cnt0(cnt0_a), .cnt1(cnt1_a)
  );

  dmux2 #(.WIDTH(1), .IDLE_VAL(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .s0(s0_b), .d0(d0_b),
    .z0(z0_b), .z1(z1_b), .z0_vld(z0v_b), .z1_vld(z1v_b),
    .cnt0(cnt0_b), .cnt1(cnt1_b)
  );

  dmux2 #(.WIDTH(8), .IDLE_VAL(8'hFF), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .s0(s0_c), .d0(d0_c),
    .z0(z0_c), .z1(z1_c), .z0_vld(z0v_c), .z1_vld(z1v_c),
    .cnt0(cnt0_c), .cnt1(cnt1_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b1; s0_a = 1'b1; d0_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1; s0_b = 1'b1; d0_b = 1'b1;
    rst_c = 1'b1; en_c = 1'b1; s0_c = 1'b1; d0_c = 8'h01;
    tick();
    tick();
    n_vec++;
    if ({z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_a: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected all zero",
               z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a);
    end
    n_vec++;
    if ({z0_b, z1_b, z0v_b, z1v_b, cnt0_b, cnt1_b} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_b: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected all zero",
               z0_b, z1_b, z0v_b, z1v_b, cnt0_b, cnt1_b);
    end
    n_vec++;
    if ({z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c} !== {8'hFF, 8'hFF, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_c: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected z0=ff z1=ff rest zero",
               z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c);
    end
  endtask

  task automatic test_truth_table();
    // {s0, d0, z0, z1, z0_vld, z1_vld, cnt0, cnt1}
    logic [21:0] tbl [4];
    logic [19:0] exp_v;
    tbl[0] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
    tbl[1] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
    tbl[2] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1};
    tbl[3] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2};
    rst_a = 1'b0;
    en_a  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_a  = tbl[i][21];
      d0_a  = tbl[i][20];
      exp_v = tbl[i][19:0];
      tick();
      n_vec++;
      if ({z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a} !== exp_v) begin
        n_err++;
        $display("FAIL truth_table step %0d: got %h expected %h", i,
                 {z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a}, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    en_a = 1'b0;
    s0_a = 1'b0;
    d0_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2}) begin
        n_err++;
        $display("FAIL hold cycle %0d: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected z1=1 v1=1 c0=2 c1=2",
                 i, z0_a, z1_a, z0v_a, z1v_a, cnt0_a, cnt1_a);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c0 [5];
    exp_c0[0] = 2'd1;
    exp_c0[1] = 2'd2;
    exp_c0[2] = 2'd3;
    exp_c0[3] = 2'd3;
    exp_c0[4] = 2'd3;
    rst_b = 1'b0;
    en_b  = 1'b1;
    s0_b  = 1'b0;
    d0_b  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (cnt0_b !== exp_c0[i] || cnt1_b !== 2'd0 || z0v_b !== 1'b1 || z1v_b !== 1'b0) begin
        n_err++;
        $display("FAIL saturation cycle %0d: got c0=%0d c1=%0d v0=%b v1=%b, expected c0=%0d c1=0 v0=1 v1=0",
                 i, cnt0_b, cnt1_b, z0v_b, z1v_b, exp_c0[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst_c = 1'b0;
    en_c  = 1'b1;
    s0_c  = 1'b0;
    d0_c  = 8'h5A;
    tick();
    n_vec++;
    if ({z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c} !== {8'h5A, 8'hFF, 1'b1, 1'b0, 8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL route_5a: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected z0=5a z1=ff v0=1 c0=1",
               z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c);
    end
    rst_c = 1'b1;
    tick();
    n_vec++;
    if ({z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c} !== {8'hFF, 8'hFF, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL mid_reset: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected z0=ff z1=ff rest zero",
               z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c);
    end
    rst_c = 1'b0;
    s0_c  = 1'b1;
    d0_c  = 8'hA5;
    tick();
    n_vec++;
    if ({z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c} !== {8'hFF, 8'hA5, 1'b0, 1'b1, 8'd0, 8'd1}) begin
      n_err++;
      $display("FAIL resume: got z0=%h z1=%h v0=%b v1=%b c0=%0d c1=%0d, expected z0=ff z1=a5 v1=1 c1=1",
               z0_c, z1_c, z0v_c, z1v_c, cnt0_c, cnt1_c);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_truth_table();
    test_hold();
    test_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
